lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Receive-side counterpart of the team's 20-bit, 2-bit-per-clock LFSR random generator. Consumes the generator's 8-bit output stream, reconstructs the full 20-bit LFSR state from consecutive samples with no seed needed, locks onto the sequence, then predicts every following sample and counts mismatches. Sits on the random-number path as a built-in self-check and bench monitor; it never drives the generator.

## Interface
- `LOCK_CNT`, 4: consecutive matching samples needed in VERIFY before `locked` asserts (1..15).
- `LOSS_CNT`, 4: consecutive mismatches in LOCKED that force re-acquisition (1..15).
- `ERR_W`, 16: width of `err_cnt`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `in_data` is valid. One assertion equals one generator step.
- `in_data` in 8: generator sample, equal to LFSR state bits [7:0].
- `clr` in 1: synchronous clear of `err_cnt` only.
- `locked` out 1: checker is in sync with the stream.
- `err_pulse` out 1: one-cycle pulse per mismatching sample in VERIFY or LOCKED.
- `err_cnt` out ERR_W: saturating mismatch count.
- `state_o` out 2: current FSM state, for debug.

## Operation
- LFSR model, with S the 20-bit state:
  - next = {S[18]^S[1], S[17]^S[0], S[19:2]}.
  - Sample D = S[7:0].
  - Consecutive samples overlap: D(k+1)[5:0] = D(k)[7:2].
- The model advances only on `in_valid`. Cycles with `in_valid` low change nothing.
- **FSM encoding**: ACQUIRE=0, VERIFY=1, LOCKED=2.
- **ACQUIRE**:
  - The first valid sample loads cap[7:0].
  - Sample j (1..6) loads cap[2j+7:2j+6] from D[7:6].
  - After 7 samples, cap = S(k), the state at the first sample.
  - If cap ≠ 0: predicted state ← next applied 7 times to cap, go to VERIFY.
  - If cap == 0: restart ACQUIRE (illegal state).
- **VERIFY**, per valid sample:
  - Compare `in_data` with pred[7:0], then pred ← next(pred).
  - Match: increment the match counter. At `LOCK_CNT`, go to LOCKED.
  - Mismatch: pulse `err_pulse`, increment `err_cnt`, return to ACQUIRE and clear the capture index.
- **LOCKED**, per valid sample:
  - Compare and advance as in VERIFY.
  - Mismatch: `err_pulse`, `err_cnt`++, increment the consecutive-miss counter.
  - Match: clear the consecutive-miss counter.
  - Miss counter reaching `LOSS_CNT`: go to ACQUIRE, drop `locked`.
- **`err_cnt`**:
  - Saturates at all-ones.
  - `clr` zeroes it. If `clr` and a mismatch occur in the same cycle, `clr` wins and the result is 0.
- `locked` is 1 exactly when state == LOCKED.

## Timing
- All outputs are registered. The response to the sample presented at cycle t is visible at cycle t+1.
- Minimum lock latency: 7 + `LOCK_CNT` valid samples. With defaults, `locked` rises the cycle after the 11th valid sample.
- Loss latency: `locked` falls the cycle after the `LOSS_CNT`-th consecutive mismatch. That sample also produces `err_pulse`.
- `err_pulse` is high for exactly one cycle per mismatching valid sample. Back-to-back mismatches give back-to-back pulses.
- Reset values:
  - State ACQUIRE, capture index 0, cap and pred 0.
  - `locked`=0, `err_pulse`=0, `err_cnt`=0, `state_o`=0.
- `rst` asserted mid-operation aborts any state. A valid sample in the reset cycle is ignored.

## Configuration
- `LFSR_CHK_OVERLAP_EN` defined:
  - In ACQUIRE, each sample j≥1 must satisfy `in_data`[5:0] == previous sample[7:2].
  - A violation restarts acquisition, with the current sample treated as the new sample 0.
  - No `err_pulse` and no count.
- Undefined: overlap bits are ignored during ACQUIRE. Errors are only detected from VERIFY onward.

## Structure
- Shared package `rand_pkg`, shared with the generator, contains:
  - `LFSR_W`=20, `OUT_W`=8, `ACQ_SAMPLES`=7.
  - The FSM state typedef/encoding.
  - The `lfsr_next` function.
- One sub-module, `lfsr_step`: combinational next-state for a given step count (parameter `STEPS`).
  - Instantiated with STEPS=7 for the ACQUIRE→VERIFY load.
  - Instantiated with STEPS=1 for per-sample prediction.

## Test plan
- **Lock from seed**: generator seed 20'h00001, `in_valid`=1 continuously → `locked` rises the cycle after sample 11; `err_cnt` stays 0 for 1000 samples.
- **Single error**: once locked, XOR bit 0 of one sample → one `err_pulse`, `err_cnt`=1, `locked` stays 1, next sample matches.
- **Loss of sync**: once locked, corrupt 4 consecutive samples → 4 pulses, `err_cnt`=4, `locked` falls after the 4th; the clean stream then re-locks after 11 more samples.
- **Zero stream**: `in_data`=8'h00 continuously → never leaves ACQUIRE, `err_cnt`=0.
- **Valid gaps**: random `in_valid` gaps with the generator clock-enabled by the same `in_valid` → lock at the 11th valid sample, no errors.
- **Reset/clr**:
  - `rst` mid-LOCKED → all outputs 0 the next cycle.
  - `clr` coincident with a mismatch → `err_cnt`=0.

Source files
------------

// File: rtl/rand_pkg.sv
// rand_pkg: definitions shared by the 20-bit, 2-bit-per-clock LFSR random generator and
// its receive-side checker.
//   LFSR_W / OUT_W / ACQ_SAMPLES : state width, sample width, samples needed to rebuild state
//   chk_state_e                  : checker FSM encoding (ACQUIRE=0, VERIFY=1, LOCKED=2)
//   lfsr_next()                  : one generator step (two new bits enter at the top)
package rand_pkg;

    localparam int unsigned LFSR_W      = 20;
    localparam int unsigned OUT_W       = 8;
    localparam int unsigned ACQ_SAMPLES = 7;

    typedef enum logic [1:0] {
        StAcquire = 2'd0,
        StVerify  = 2'd1,
        StLocked  = 2'd2
    } chk_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[18] ^ s[1], s[17] ^ s[0], s[19:2]};
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: sample stream in, lock/error status out.
//   in_valid, in_data, clr          : driven by the master (stream source / bench)
//   locked, err_pulse, err_cnt,
//   state_o                         : driven by the slave (lfsr_checker)
interface lfsr_checker_if
    import rand_pkg::*;
#(
    parameter int unsigned ERR_W = 16
) ();

    logic             in_valid;
    logic [OUT_W-1:0] in_data;
    logic             clr;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       state_o;

    modport master (
        output in_valid, in_data, clr,
        input  locked, err_pulse, err_cnt, state_o
    );

    modport slave (
        input  in_valid, in_data, clr,
        output locked, err_pulse, err_cnt, state_o
    );

endinterface

// File: rtl/lfsr_step.sv
// lfsr_step: combinational advance of the LFSR state by STEPS generator steps.
//   state_i : current 20-bit state
//   state_o : state after STEPS applications of lfsr_next
module lfsr_step
    import rand_pkg::*;
#(
    parameter int unsigned STEPS = 1
) (
    input  logic [LFSR_W-1:0] state_i,
    output logic [LFSR_W-1:0] state_o
);

    always_comb begin
        logic [LFSR_W-1:0] s;
        s = state_i;
        for (int unsigned i = 0; i < STEPS; i++) begin
            s = lfsr_next(s);
        end
        state_o = s;
    end

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: rebuilds the generator's 20-bit state from 7 consecutive samples, verifies
// LOCK_CNT predictions, then tracks the stream and counts mismatching samples.
//   clk, rst  : clock, synchronous active-high reset
//   bus_io    : lfsr_checker_if.slave (in_valid/in_data/clr in; locked/err_pulse/err_cnt/state_o out)
// Optional: define LFSR_CHK_OVERLAP_EN to check sample overlap bits during acquisition.
module lfsr_checker
    import rand_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned ERR_W    = 16
) (
    input logic            clk,
    input logic            rst,
    lfsr_checker_if.slave  bus_io
);

    chk_state_e        state_q, state_d;
    logic [2:0]        idx_q, idx_d, eff_idx;
    logic [LFSR_W-1:0] cap_q, cap_d, cap_full;
    logic [LFSR_W-1:0] pred_q, pred_d, pred_load, pred_next;
    logic [3:0]        match_q, match_d, miss_q, miss_d;
    logic              err_q, err_d;
    logic [ERR_W-1:0]  cnt_q, cnt_d;
    logic              hit, overlap_bad;

`ifdef LFSR_CHK_OVERLAP_EN
    logic [OUT_W-1:0] prev_q;

    // A sample whose low 6 bits do not continue the previous one restarts capture with itself.
    assign overlap_bad = (state_q == StAcquire) && bus_io.in_valid && (idx_q != 3'd0) &&
                         (bus_io.in_data[5:0] != prev_q[7:2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
        end else if (bus_io.in_valid && state_q == StAcquire) begin
            prev_q <= bus_io.in_data;
        end
    end
`else
    assign overlap_bad = 1'b0;
`endif

    assign eff_idx = overlap_bad ? 3'd0 : idx_q;
    assign hit     = (bus_io.in_data == pred_q[7:0]);

    // Capture register including the current sample: sample 0 fills [7:0], sample j fills
    // the two new top bits at [2j+7:2j+6].
    always_comb begin
        cap_full = cap_q;
        if (eff_idx == 3'd0) begin
            cap_full[7:0] = bus_io.in_data;
        end
        for (int j = 1; j < int'(ACQ_SAMPLES); j++) begin
            if (eff_idx == 3'(j)) begin
                cap_full[2*j+7 -: 2] = bus_io.in_data[7:6];
            end
        end
    end

    // cap_full holds the state at the first sample; the next expected sample is 7 steps on.
    lfsr_step #(.STEPS(ACQ_SAMPLES)) u_step_load (
        .state_i (cap_full),
        .state_o (pred_load)
    );

    lfsr_step #(.STEPS(1)) u_step_pred (
        .state_i (pred_q),
        .state_o (pred_next)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        pred_d  = pred_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        if (bus_io.in_valid) begin
            unique case (state_q)
                StAcquire: begin
                    cap_d = cap_full;
                    if (eff_idx == 3'(ACQ_SAMPLES - 1)) begin
                        idx_d = 3'd0;
                        // All-zero is the LFSR lock-up state; keep acquiring.
                        if (cap_full != '0) begin
                            pred_d  = pred_load;
                            match_d = 4'd0;
                            state_d = StVerify;
                        end
                    end else begin
                        idx_d = eff_idx + 3'd1;
                    end
                end
                StVerify: begin
                    pred_d = pred_next;
                    if (hit) begin
                        if (match_q == 4'(LOCK_CNT - 1)) begin
                            match_d = 4'd0;
                            miss_d  = 4'd0;
                            state_d = StLocked;
                        end else begin
                            match_d = match_q + 4'd1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        idx_d   = 3'd0;
                        state_d = StAcquire;
                    end
                end
                StLocked: begin
                    pred_d = pred_next;
                    if (hit) begin
                        miss_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                        if (miss_q == 4'(LOSS_CNT - 1)) begin
                            miss_d  = 4'd0;
                            idx_d   = 3'd0;
                            state_d = StAcquire;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
                default: begin
                    idx_d   = 3'd0;
                    state_d = StAcquire;
                end
            endcase
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (bus_io.clr) begin
            cnt_d = '0;
        end else if (err_d && cnt_q != '1) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAcquire;
            idx_q   <= 3'd0;
            cap_q   <= '0;
            pred_q  <= '0;
            match_q <= 4'd0;
            miss_q  <= 4'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            pred_q  <= pred_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_io.locked    = (state_q == StLocked);
    assign bus_io.err_pulse = err_q;
    assign bus_io.err_cnt   = cnt_q;
    assign bus_io.state_o   = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: scoreboard bench for lfsr_checker. A driver issues one cycle of stimulus
// at a time and stages the reference model's expected outputs; a monitor compares them
// against the DUT on the following falling edge.
module tb_lfsr_checker;

    localparam int unsigned ERR_W   = 4;  // narrow so the random phase reaches saturation
    localparam int          LOCK_N  = 4;
    localparam int          LOSS_N  = 4;
    localparam int          CNT_MAX = (1 << ERR_W) - 1;

    typedef struct packed {
        logic             locked;
        logic             pulse;
        logic [ERR_W-1:0] cnt;
        logic [1:0]       st;
    } exp_t;

    logic clk;
    logic rst;

    lfsr_checker_if #(.ERR_W(ERR_W)) bus ();

    lfsr_checker #(
        .LOCK_CNT (LOCK_N),
        .LOSS_CNT (LOSS_N),
        .ERR_W    (ERR_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t stage;
    logic stage_vld = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model (stream-level view of the checker) ----------------
    int          m_mode;   // 0 acquire, 1 verify, 2 locked
    logic [7:0]  m_acq[$]; // samples captured so far in the current acquisition
    logic [19:0] m_pred;   // predicted generator state for the next sample
    int          m_match, m_miss, m_cnt;
    logic        m_pulse;

    function automatic logic [19:0] adv(input logic [19:0] s, input int n);
        logic [19:0] r;
        r = s;
        for (int i = 0; i < n; i++) begin
            r = (r >> 2) | (20'(r[18] ^ r[1]) << 19) | (20'(r[17] ^ r[0]) << 18);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_acq.delete(); m_pred = '0;
        m_match = 0; m_miss = 0; m_cnt = 0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic c);
        logic [19:0] s;
        logic        hit;
        m_pulse = 1'b0;
        if (v) begin
            if (m_mode == 0) begin
`ifdef LFSR_CHK_OVERLAP_EN
                if (m_acq.size() > 0 && d[5:0] != m_acq[m_acq.size()-1][7:2]) m_acq.delete();
`endif
                m_acq.push_back(d);
                if (m_acq.size() == 7) begin
                    s = 20'(m_acq[0]);
                    for (int j = 1; j < 7; j++) s = s | (20'(m_acq[j][7:6]) << (2*j + 6));
                    m_acq.delete();
                    if (s != 0) begin
                        m_pred = adv(s, 7); m_mode = 1; m_match = 0;
                    end
                end
            end else begin
                hit    = (d == m_pred[7:0]);
                m_pred = adv(m_pred, 1);
                if (m_mode == 1) begin
                    if (hit) begin
                        m_match++;
                        if (m_match == LOCK_N) begin m_mode = 2; m_miss = 0; end
                    end else begin
                        m_pulse = 1'b1; m_mode = 0;
                    end
                end else begin
                    if (hit) m_miss = 0;
                    else begin
                        m_pulse = 1'b1; m_miss++;
                        if (m_miss == LOSS_N) m_mode = 0;
                    end
                end
            end
        end
        if (c) m_cnt = 0;
        else if (m_pulse && m_cnt < CNT_MAX) m_cnt++;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.locked = (m_mode == 2);
        e.pulse  = m_pulse;
        e.cnt    = ERR_W'(m_cnt);
        e.st     = 2'(m_mode);
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        if (stage_vld) begin
            exp_q.push_back(stage);
            stage_vld = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_locked", int'(bus.locked), int'(e.locked));
            chk("sb_err_pulse", int'(bus.err_pulse), int'(e.pulse));
            chk("sb_err_cnt", int'(bus.err_cnt), int'(e.cnt));
            chk("sb_state", int'(bus.state_o), int'(e.st));
        end
    end

    // ---------------- driver ----------------
    logic [19:0] g; // generator state

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        bus.in_valid = v; bus.in_data = d; bus.clr = c;
        model_step(v, d, c);
        stage = model_out(); stage_vld = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'($urandom); bus.clr = 1'b0;
        model_reset();
        stage = model_out(); stage_vld = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic gen_sample(input logic [7:0] flip, input logic c);
        step(1'b1, g[7:0] ^ flip, c);
        g = adv(g, 1);
    endtask

    initial begin
        int lock_at;
        int vcnt;
        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.clr = 1'b0;
        do_reset();
        chk("reset_locked", int'(bus.locked), 0);
        chk("reset_state", int'(bus.state_o), 0);

        // Lock from seed 1, then 1000 clean samples.
        g = 20'h00001; lock_at = 0;
        for (int i = 1; i <= 1000; i++) begin
            gen_sample(8'h00, 1'b0);
            if (bus.locked && lock_at == 0) lock_at = i;
        end
        chk("lock_sample_seed1", lock_at, 11);
        chk("clean_err_cnt", int'(bus.err_cnt), 0);

        // Single bit error while locked.
        gen_sample(8'h01, 1'b0);
        chk("single_pulse", int'(bus.err_pulse), 1);
        chk("single_cnt", int'(bus.err_cnt), 1);
        chk("single_locked", int'(bus.locked), 1);
        gen_sample(8'h00, 1'b0);
        chk("single_next_pulse", int'(bus.err_pulse), 0);

        // Loss of sync: clear, then 4 consecutive corrupted samples.
        gen_sample(8'h00, 1'b1);
        chk("clr_cnt", int'(bus.err_cnt), 0);
        for (int i = 1; i <= 4; i++) begin
            gen_sample(8'hA5, 1'b0);
            chk("loss_pulse", int'(bus.err_pulse), 1);
            chk("loss_locked", int'(bus.locked), (i < 4) ? 1 : 0);
        end
        chk("loss_cnt", int'(bus.err_cnt), 4);
        lock_at = 0;
        for (int i = 1; i <= 30; i++) begin
            gen_sample(8'h00, 1'b0);
            if (bus.locked && lock_at == 0) lock_at = i;
        end
        chk("relock_sample", lock_at, 11);

        // clr coincident with a mismatch.
        gen_sample(8'h10, 1'b1);
        chk("clr_vs_err_pulse", int'(bus.err_pulse), 1);
        chk("clr_vs_err_cnt", int'(bus.err_cnt), 0);

        // Reset mid-LOCKED.
        chk("pre_reset_locked", int'(bus.locked), 1);
        do_reset();
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_pulse", int'(bus.err_pulse), 0);
        chk("rst_cnt", int'(bus.err_cnt), 0);
        chk("rst_state", int'(bus.state_o), 0);

        // Zero stream never leaves ACQUIRE.
        for (int i = 0; i < 50; i++) step(1'b1, 8'h00, 1'b0);
        chk("zero_state", int'(bus.state_o), 0);
        chk("zero_cnt", int'(bus.err_cnt), 0);

        // Random valid gaps; generator advances only with in_valid.
        do_reset();
        g = 20'($urandom_range(1, (1 << 20) - 1));
        lock_at = 0; vcnt = 0;
        for (int i = 0; i < 200 && vcnt < 30; i++) begin
            if ($urandom_range(0, 2) == 0) step(1'b0, 8'($urandom), 1'b0);
            else begin
                vcnt++;
                gen_sample(8'h00, 1'b0);
                if (bus.locked && lock_at == 0) lock_at = vcnt;
            end
        end
        chk("gaps_lock_sample", lock_at, 11);
        chk("gaps_cnt", int'(bus.err_cnt), 0);

        // Random corruption, gaps and clears.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) step(1'b0, 8'($urandom), $urandom_range(0, 49) == 0);
            else if ($urandom_range(0, 99) < 15)
                gen_sample(8'($urandom_range(1, 255)), $urandom_range(0, 49) == 0);
            else gen_sample(8'h00, $urandom_range(0, 49) == 0);
        end

        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
